par2ser_16: RTL and testbench

- Parallel-to-serial converter with handshakes on both sides.
- Accepts one WIDTH-bit word per transaction and emits it LSB-first, one bit per accepted cycle.
- Each shift-register bit's next value is chosen by a per-bit 2:1 select between load data and the shifted neighbour.
- Sits directly downstream of the hw1 2:1 mux stage and consumes its select structure as the datapath element.

---
 rtl/par2ser_16.sv | 86 ++++++++
 tb/tb_par2ser_16.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/par2ser_16.sv
// Parallel-to-serial converter: loads one WIDTH-bit word, emits it LSB-first
// with a valid/ready handshake on the serial side and a Done flag on the MSB.
module par2ser_16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] InData,
  input  logic             InValid,
  output logic             InReady,
  output logic             SerOut,
  output logic             SerValid,
  input  logic             SerReady,
  output logic             Done,
  output logic             Busy
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load, xfer, last;

  // Outputs depend only on registered state, gated off while reset is held
  always_comb begin
    InReady  = !rst && (state == IDLE);
    Busy     = !rst && (state == SHIFT);
    SerValid = Busy;
    SerOut   = Busy && shreg[0];
    Done     = Busy && last;
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign load = (state == IDLE) && InValid;
  assign xfer = (state == SHIFT) && SerReady;

  // Per-bit 2:1 select between load data and the upper neighbour
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic sh_in;
    if (i == WIDTH - 1) begin : g_top
      assign sh_in = 1'b0;
    end else begin : g_mid
      assign sh_in = shreg[i+1];
    end
    assign shreg_nxt[i] = load ? InData[i] : (xfer ? sh_in : shreg[i]);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (last) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_par2ser_16.sv
// Scoreboard bench for par2ser_16: the driver queues expected serial bits at
// each load, a negedge monitor pops and compares on every serial transfer.
module tb_par2ser_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] InData;
  logic        InValid;
  logic        InReady;
  logic        SerOut;
  logic        SerValid;
  logic        SerReady;
  logic        Done;
  logic        Busy;

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  logic [1:0] sb[$];  // {expected bit, expected Done}

  par2ser_16 #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .InData(InData), .InValid(InValid), .InReady(InReady),
    .SerOut(SerOut), .SerValid(SerValid), .SerReady(SerReady), .Done(Done), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) sb.push_back({w[i], (i == 15) ? 1'b1 : 1'b0});
  endtask

  // Called at posedge+1; waits for InReady, loads w on the next edge
  task automatic load_word(input logic [15:0] w);
    int n = 0;
    InData  = w;
    InValid = 1'b1;
    while (!InReady && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 200) chk("load_timeout", 32'(n), 32'd0);
    push_word(w);
    @(posedge clk); #1;
    InValid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: a transfer happens on the coming edge when SerValid && SerReady
  always @(negedge clk) begin
    if (!rst && SerValid && SerReady) begin
      xfers++;
      if (sb.size() == 0) begin
        chk("ser_unexpected", 32'd1, 32'd0);
      end else begin
        logic [1:0] e;
        e = sb.pop_front();
        chk("ser_bit_done", {30'd0, SerOut, Done}, {30'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, stall_done, x0, n;
    rst = 1'b1; InData = '0; InValid = 1'b0; SerReady = 1'b1;

    // Reset: every output low while rst is held
    cycles(2);
    @(negedge clk);
    chk("reset_outs", {27'd0, InReady, SerOut, SerValid, Done, Busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {27'd0, InReady, SerOut, SerValid, Done, Busy}, 32'b10000);
    @(posedge clk); #1;

    // A5C3 at full rate, InReady back exactly 17 cycles after load
    load_word(16'hA5C3);
    cycles(16);
    @(negedge clk);
    chk("a5c3_inready_after", {30'd0, InReady, Busy}, 32'b10);
    @(posedge clk); #1;

    // FFFF with SerReady toggling 1,0,1,0...
    x0 = xfers;
    load_word(16'hFFFF);
    busy_cnt = 0; stall_done = 0;
    for (int k = 0; k < 40; k++) begin
      SerReady = (k % 2 == 0);
      @(negedge clk);
      if (Busy) busy_cnt++;
      if (Busy && !SerReady && Done) stall_done++;
      @(posedge clk); #1;
    end
    SerReady = 1'b1;
    chk("ffff_busy_cycles", 32'(busy_cnt), 32'd31);
    chk("ffff_stalled_done", 32'(stall_done), 32'd1);
    chk("ffff_transfers", 32'(xfers - x0), 32'd16);

    // Back-to-back 0001 / 8000 with InValid held high: one bubble
    InData = 16'h0001; InValid = 1'b1;
    @(negedge clk);
    chk("b2b_ready", {31'd0, InReady}, 32'd1);
    push_word(16'h0001);
    @(posedge clk); #1;
    InData = 16'h8000;
    push_word(16'h8000);
    cycles(16);
    @(negedge clk);
    chk("b2b_bubble", {30'd0, SerValid, InReady}, 32'b01);
    @(posedge clk); #1;
    InValid = 1'b0;
    @(negedge clk);
    chk("b2b_second_busy", {31'd0, Busy}, 32'd1);
    @(posedge clk); #1;
    cycles(16);

    // Mid-word reset after 5 bits of 1234
    load_word(16'h1234);
    cycles(5);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_outs", {27'd0, InReady, SerOut, SerValid, Done, Busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", {27'd0, InReady, SerOut, SerValid, Done, Busy}, 32'b10000);
    @(posedge clk); #1;
    load_word(16'h000F);
    cycles(16);

    // InValid/InData churn during SHIFT must not disturb or reload
    load_word(16'h5A5A);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      InValid = 1'b1;
      InData  = (k < 8) ? 16'hDEAD : 16'hBEEF;
      @(negedge clk);
      if (InReady) n++;
      @(posedge clk); #1;
    end
    InValid = 1'b0;
    chk("churn_inready", 32'(n), 32'd0);
    @(negedge clk);
    chk("churn_idle1", {31'd0, Busy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("churn_idle2", {31'd0, Busy}, 32'd0);
    @(posedge clk); #1;

    // Sweep: walking ones plus random words under random back-pressure
    for (int i = 0; i < 136; i++) begin
      logic [15:0] w;
      logic [15:0] one;
      one = 16'h0001;
      w = (i < 16) ? (one << i) : 16'($urandom);
      load_word(w);
      for (int k = 0; k < 20; k++) begin
        SerReady = ($urandom_range(0, 3) != 0);
        cycles(1);
      end
      SerReady = 1'b1;
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      cycles(1);
      n++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
